// File: rtl/csa_resolve_pkg.sv
// Shared widths and FSM state type for the carry-save column resolve stage.
package csa_resolve_pkg;

  localparam int DIGIT_W = 16;
  localparam int ACC_W   = 20;
  // Carry held between columns; derived from the other two widths.
  localparam int CARRY_W = ACC_W + 2 - DIGIT_W;

  // RUN accepts columns; FLUSH owes the residual-carry digit.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage : csa_resolve_pkg

// File: rtl/csa_column_resolve.sv
// Sequential carry-resolve stage: takes one redundant (C, S) column per cycle,
// least-significant column first, adds the carry left from the previous column
// and emits one normalized DIGIT_W digit per column.
//
// Build option: define CSA_RESOLVE_FLUSH_EN to emit one extra digit holding the
// residual carry after each operand (carry_out is then constant 0). Without it
// the in_last digit carries out_last and carry_out holds the residual carry.
//
// Handshake: a transfer happens on a port when valid & ready are both high at
// the rising clock edge. out_valid, once raised, holds with out_digit,
// out_last and carry_out stable until out_ready. in_valid must not depend on
// in_ready. The only combinational path from out_ready is to in_ready.
module csa_column_resolve
  import csa_resolve_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_c,
  input  logic [ACC_W-1:0]   in_s,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic [CARRY_W-1:0] carry_out
);

  state_t             state;
  state_t             state_next;
  logic [CARRY_W-1:0] carry_q;
  logic [ACC_W+1:0]   sum;
  logic               out_free;
  logic               in_fire;

  // Output register can take a new digit when empty or being drained.
  assign out_free = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Column adder: carry_q <= 32 keeps the sum below 2^22, so nothing is lost.
  assign sum = {2'b00, in_c} + {2'b00, in_s}
             + {{(ACC_W + 2 - CARRY_W){1'b0}}, carry_q};

`ifdef CSA_RESOLVE_FLUSH_EN
  logic [CARRY_W-1:0] flush_carry_q;
  logic               flush_take;

  // In FLUSH the residual digit moves into the output register once it frees up.
  assign flush_take = (state == FLUSH) && out_free;
  assign carry_out  = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
`ifdef CSA_RESOLVE_FLUSH_EN
    unique case (state)
      RUN:     if (in_fire && in_last) state_next = FLUSH;
      FLUSH:   if (flush_take)         state_next = RUN;
      default: state_next = RUN;
    endcase
`else
    state_next = RUN;
`endif
  end

  // FSM outputs: columns are accepted only in RUN with room at the output.
  always_comb begin
    in_ready = (state == RUN) && out_free;
  end

  // Carry register and output register; reset drops any partial operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q   <= '0;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_last  <= 1'b0;
`ifdef CSA_RESOLVE_FLUSH_EN
      flush_carry_q <= '0;
`else
      carry_out <= '0;
`endif
    end else if (in_fire) begin
      // The next operand always starts from zero carry.
      carry_q   <= in_last ? '0 : sum[ACC_W+1:DIGIT_W];
      out_valid <= 1'b1;
      out_digit <= sum[DIGIT_W-1:0];
`ifdef CSA_RESOLVE_FLUSH_EN
      out_last      <= 1'b0;
      flush_carry_q <= sum[ACC_W+1:DIGIT_W];
`else
      out_last  <= in_last;
      carry_out <= in_last ? sum[ACC_W+1:DIGIT_W] : '0;
`endif
`ifdef CSA_RESOLVE_FLUSH_EN
    end else if (flush_take) begin
      out_valid <= 1'b1;
      out_digit <= {{(DIGIT_W - CARRY_W){1'b0}}, flush_carry_q};
      out_last  <= 1'b1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : csa_column_resolve

// File: tb/tb_csa_column_resolve.sv
// Self-checking bench for csa_column_resolve. Expected digits come from a
// big-integer sum of each operand's columns. Honours CSA_RESOLVE_FLUSH_EN.
module tb_csa_column_resolve;

  localparam int BW = 1120;
`ifdef CSA_RESOLVE_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic [5:0]  co;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_c;
  logic [19:0] in_s;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_digit;
  logic        out_last;
  logic [5:0]  carry_out;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [19:0] col_c[$];
  logic [19:0] col_s[$];
  rec_t        exp_q[$];
  rec_t        got_q[$];
  rec_t        last_got[$];
  bit          rand_ready = 0;
  bit          acc;
  bit          prev_stall = 0;
  logic [22:0] prev_out;

  csa_column_resolve dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_s      (in_s),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_last  (out_last),
    .carry_out (carry_out)
  );

  // Clock and global watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: the operand value is sum of (C+S) * 2^(16*i).
  function automatic void model_operand();
    logic [BW-1:0] total;
    int            n;
    rec_t          r;
    n     = col_c.size();
    total = '0;
    for (int i = 0; i < n; i++)
      total = total + ((BW'(col_c[i]) + BW'(col_s[i])) << (16 * i));
    for (int i = 0; i < n; i++) begin
      r.d  = total[16*i +: 16];
      r.l  = !FLUSH_EN && (i == n - 1);
      r.co = r.l ? total[16*n +: 6] : 6'd0;
      exp_q.push_back(r);
    end
    if (FLUSH_EN) begin
      r.d  = total[16*n +: 16];
      r.l  = 1'b1;
      r.co = 6'd0;
      exp_q.push_back(r);
    end
    col_c.delete();
    col_s.delete();
  endfunction

  // One cycle: called at negedge, samples 2 time units later, returns at next negedge.
  task automatic tick();
    rec_t r;
    acc = 1'b0;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #2;
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_payload", 32'({out_digit, out_last, carry_out}), 32'(prev_out));
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_digit, out_last, carry_out};
      if (out_valid && out_ready) begin
        r.d  = out_digit;
        r.l  = out_last;
        r.co = carry_out;
        got_q.push_back(r);
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        col_c.push_back(in_c);
        col_s.push_back(in_s);
        if (in_last) model_operand();
      end
    end else begin
      prev_stall = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send_col(input logic [19:0] c, input logic [19:0] s, input logic l,
                          output int waits);
    in_c     = c;
    in_s     = s;
    in_last  = l;
    in_valid = 1'b1;
    waits    = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (acc) break;
      waits++;
    end
    chk("accept_timeout", 32'(waits < 100), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    col_c.delete();
    col_s.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  // Empty the pipe and compare every collected digit with the model.
  task automatic drain(input string tag);
    int   k;
    rec_t g;
    rec_t e;
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    k = 0;
    while ((out_valid || got_q.size() < exp_q.size()) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_drain_timeout"}, 32'(k < 200), 32'd1);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    last_got.delete();
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      last_got.push_back(g);
      chk({tag, "_digit"}, 32'(g.d), 32'(e.d));
      chk({tag, "_last"}, 32'(g.l), 32'(e.l));
      if (e.l) chk({tag, "_carry_out"}, 32'(g.co), 32'(e.co));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_c      = '0;
    in_s      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    do_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_digit", 32'(out_digit), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_carry_out", 32'(carry_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-column operand.
    send_col(20'h0FFFF, 20'h00001, 1'b1, w);
    drain("single");
    chk("single_d0", 32'(last_got[0].d), 32'h0000);
`ifdef CSA_RESOLVE_FLUSH_EN
    chk("single_d0_last", 32'(last_got[0].l), 32'd0);
    chk("single_flush_d", 32'(last_got[1].d), 32'h0001);
    chk("single_flush_last", 32'(last_got[1].l), 32'd1);
`else
    chk("single_d0_last", 32'(last_got[0].l), 32'd1);
    chk("single_co", 32'(last_got[0].co), 32'd1);
`endif

    // Two columns, worst-case carry.
    send_col(20'hFFFFF, 20'hFFFFF, 1'b0, w);
    send_col(20'h00000, 20'h00001, 1'b1, w);
    drain("worst");
    chk("worst_d0", 32'(last_got[0].d), 32'hFFFE);
    chk("worst_d1", 32'(last_got[1].d), 32'h0020);
`ifdef CSA_RESOLVE_FLUSH_EN
    chk("worst_flush_d", 32'(last_got[2].d), 32'h0000);
`else
    chk("worst_co", 32'(last_got[1].co), 32'd0);
`endif

    // Backpressure for three cycles mid-stream.
    send_col(20'h01234, 20'h00011, 1'b0, w);
    out_ready = 1'b0;
    in_c      = 20'h0000F;
    in_s      = 20'h00001;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_digit", 32'(out_digit), 32'h1245);
      tick();
    end
    out_ready = 1'b1;
    send_col(20'h0000F, 20'h00001, 1'b0, w);
    send_col(20'h00007, 20'h00003, 1'b1, w);
    drain("bp");

    // Back-to-back operands.
    send_col(20'hFFFFF, 20'h00002, 1'b1, w);
    send_col(20'h00005, 20'h00006, 1'b0, w);
    chk("b2b_bubble", 32'(w), FLUSH_EN ? 32'd1 : 32'd0);
    send_col(20'h00000, 20'h00000, 1'b1, w);
    drain("b2b");
    chk("b2b_op2_d0", 32'(last_got[FLUSH_EN ? 2 : 1].d), 32'h000B);

    // Reset mid-operand with carry 5 and a pending digit.
    send_col(20'h50000, 20'h00000, 1'b0, w);
    out_ready = 1'b0;
    #1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_valid", 32'(out_valid), 32'd0);
    col_c.delete();
    col_s.delete();
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b1;
    send_col(20'h00001, 20'h00002, 1'b1, w);
    drain("mid");
    chk("mid_d0", 32'(last_got[0].d), 32'h0003);

    // Random 64-column operands with random gaps and backpressure.
    for (int op = 0; op < 3; op++) begin
      rand_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
        in_valid = 1'b0;
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        send_col(20'($urandom_range(0, 20'hFFFFF)), 20'($urandom_range(0, 20'hFFFFF)),
                 (i == 63), w);
      end
      drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_csa_column_resolve
